// File: rtl/usb_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler_if
// Purpose  : Bundles the endpoint request/FIFO side and the PHY TX channel
//            of the USB TX scheduler into one port.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_tx_scheduler_if #(
  parameter int NUM_EP = 4,
  parameter int LEN_W  = 7
);
  logic                    usb_reset;
  logic [NUM_EP-1:0]       req;
  logic [4*NUM_EP-1:0]     pid;
  logic [LEN_W*NUM_EP-1:0] len;
  logic [NUM_EP-1:0]       gnt;
  logic [NUM_EP-1:0]       done;
  logic                    underrun;
  logic [8*NUM_EP-1:0]     fifo_q;
  logic [NUM_EP-1:0]       fifo_empty;
  logic [NUM_EP-1:0]       fifo_rdreq;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  // Scheduler side: consumes requests and FIFO heads, drives the PHY
  modport master (
    input  usb_reset, req, pid, len, fifo_q, fifo_empty, tx_ready,
    output gnt, done, underrun, fifo_rdreq, tx_data, tx_valid
  );

  // Environment side: endpoints, FIFOs and PHY
  modport slave (
    output usb_reset, req, pid, len, fifo_q, fifo_empty, tx_ready,
    input  gnt, done, underrun, fifo_rdreq, tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler
// Purpose  : Round-robin arbiter and packet sequencer sharing one USB TX
//            channel between NUM_EP endpoints (PID, payload, CRC16).
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_scheduler #(
  parameter int NUM_EP = 4,
  parameter int LEN_W  = 7,
  parameter int GAP    = 16
) (
  input  logic              clk,
  input  logic              reset,
  usb_tx_scheduler_if.master bus
);

  localparam int EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int GAP_W = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PID      = 3'd1,
    S_DATA     = 3'd2,
    S_CRC_LO   = 3'd3,
    S_CRC_HI   = 3'd4,
    S_GAP_WAIT = 3'd5
  } state_t;

  state_t           state;
  logic [EP_W-1:0]  rr_ptr;
  logic [EP_W-1:0]  cur_ep;
  logic             is_data_pkt;
  logic [LEN_W-1:0] byte_cnt;
  logic [15:0]      crc;
  logic [GAP_W-1:0] gap_cnt;

  logic [3:0]       ep_pid [NUM_EP];
  logic [LEN_W-1:0] ep_len [NUM_EP];
  logic [7:0]       ep_q   [NUM_EP];

  logic             arb_found;
  logic [EP_W-1:0]  arb_sel;
  logic             cur_empty;
  logic [7:0]       cur_q;

  // Unpack the flat per-endpoint buses into arrays indexed by endpoint
  generate
    for (genvar i = 0; i < NUM_EP; i++) begin : g_unpack
      assign ep_pid[i] = bus.pid[4*i +: 4];
      assign ep_len[i] = bus.len[LEN_W*i +: LEN_W];
      assign ep_q[i]   = bus.fifo_q[8*i +: 8];
    end
  endgenerate

  assign cur_empty = bus.fifo_empty[cur_ep];
  assign cur_q     = ep_q[cur_ep];

  // CRC-16/USB update for one byte, reflected polynomial, LSB first
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [NUM_EP-1:0] onehot(input logic [EP_W-1:0] i);
    logic [NUM_EP-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester strictly after rr_ptr, wrapping
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_sel   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_EP; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_EP) idx = idx - NUM_EP;
      if (!arb_found && bus.req[EP_W'(idx)]) begin
        arb_found = 1'b1;
        arb_sel   = EP_W'(idx);
      end
    end
  end

  // Packet sequencer: grant, PID, payload, CRC, inter-packet gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      rr_ptr       <= EP_W'(NUM_EP - 1);
      cur_ep       <= '0;
      is_data_pkt  <= 1'b0;
      byte_cnt     <= '0;
      crc          <= 16'hFFFF;
      gap_cnt      <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.underrun <= 1'b0;
      bus.fifo_rdreq <= '0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
    end else if (bus.usb_reset) begin
      // Bus reset silently abandons any packet; arbitration history is kept
      state        <= S_IDLE;
      gap_cnt      <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.underrun <= 1'b0;
      bus.fifo_rdreq <= '0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
    end else begin
      bus.done       <= '0;
      bus.underrun   <= 1'b0;
      bus.fifo_rdreq <= '0;
      case (state)
        S_IDLE: begin
          if (arb_found && gap_cnt == '0) begin
            cur_ep       <= arb_sel;
            rr_ptr       <= arb_sel;
            is_data_pkt  <= (ep_pid[arb_sel][1:0] == 2'b11);
            byte_cnt     <= ep_len[arb_sel];
            crc          <= 16'hFFFF;
            bus.gnt      <= onehot(arb_sel);
            bus.tx_data  <= {~ep_pid[arb_sel], ep_pid[arb_sel]};
            bus.tx_valid <= 1'b1;
            state        <= S_PID;
          end
        end
        S_PID, S_DATA: begin
          if (bus.tx_ready) begin
            if (state == S_PID && !is_data_pkt) begin
              bus.done     <= bus.gnt;
              bus.gnt      <= '0;
              bus.tx_valid <= 1'b0;
              bus.tx_data  <= 8'h00;
              gap_cnt      <= GAP_W'(GAP);
              state        <= S_GAP_WAIT;
            end else if (byte_cnt == '0) begin
              bus.tx_data <= ~crc[7:0];
              state       <= S_CRC_LO;
            end else if (cur_empty) begin
              // Starved mid-payload: end the packet without a CRC
              bus.done     <= bus.gnt;
              bus.underrun <= 1'b1;
              bus.gnt      <= '0;
              bus.tx_valid <= 1'b0;
              bus.tx_data  <= 8'h00;
              gap_cnt      <= GAP_W'(GAP);
              state        <= S_GAP_WAIT;
            end else begin
              // Next byte goes out the cycle after tx_ready; pop the FIFO head
              bus.tx_data    <= cur_q;
              bus.fifo_rdreq <= onehot(cur_ep);
              byte_cnt       <= byte_cnt - 1'b1;
              crc            <= crc16_upd(crc, cur_q);
              state          <= S_DATA;
            end
          end
        end
        S_CRC_LO: begin
          if (bus.tx_ready) begin
            bus.tx_data <= ~crc[15:8];
            state       <= S_CRC_HI;
          end
        end
        S_CRC_HI: begin
          if (bus.tx_ready) begin
            bus.done     <= bus.gnt;
            bus.gnt      <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
            gap_cnt      <= GAP_W'(GAP);
            state        <= S_GAP_WAIT;
          end
        end
        S_GAP_WAIT: begin
          if (gap_cnt <= GAP_W'(1)) state <= S_IDLE;
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_scheduler
// Purpose  : Self-checking bench for usb_tx_scheduler with FIFO/PHY models
//            and an expected-byte scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_scheduler;
  localparam int NUM_EP = 4;
  localparam int LEN_W  = 7;
  localparam int GAP    = 16;

  logic clk = 1'b0;
  logic reset;

  usb_tx_scheduler_if #(.NUM_EP(NUM_EP), .LEN_W(LEN_W)) bus ();

  usb_tx_scheduler #(.NUM_EP(NUM_EP), .LEN_W(LEN_W), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pay_q[$];

  // Show-ahead FIFO model: bench writes fwr, DUT pops advance frd
  logic [7:0] fmem [NUM_EP][16];
  logic [7:0] fwr  [NUM_EP] = '{default: 8'h00};
  logic [7:0] frd  [NUM_EP] = '{default: 8'h00};

  always_comb begin
    bus.fifo_q     = '0;
    bus.fifo_empty = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      bus.fifo_q[8*i +: 8] = fmem[i][frd[i][3:0]];
      bus.fifo_empty[i]    = (fwr[i] == frd[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_EP; i++)
      if (bus.fifo_rdreq[i] === 1'b1 && fwr[i] != frd[i]) frd[i] <= frd[i] + 8'd1;
  end

  // Pulse counters observed mid-cycle
  int done_cnt [NUM_EP] = '{default: 0};
  int rd_cnt   [NUM_EP] = '{default: 0};
  int und_cnt = 0;
  int und_done_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_EP; i++) begin
      if (bus.done[i] === 1'b1) done_cnt[i]++;
      if (bus.fifo_rdreq[i] === 1'b1) rd_cnt[i]++;
    end
    if (bus.underrun === 1'b1) begin
      und_cnt++;
      if (bus.done !== '0) und_done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Expected byte stream of a packet carrying the payload in pay_q
  task automatic push_pkt(input logic [3:0] p);
    logic [15:0] c;
    exp_q.push_back({~p, p});
    if (p[1:0] == 2'b11) begin
      c = 16'hFFFF;
      foreach (pay_q[i]) begin
        exp_q.push_back(pay_q[i]);
        c = crc_model(c, pay_q[i]);
      end
      c = ~c;
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
  endtask

  task automatic fifo_push(input int ep, input logic [7:0] b);
    fmem[ep][fwr[ep][3:0]] = b;
    fwr[ep] = fwr[ep] + 8'd1;
  endtask

  task automatic set_ep(input int ep, input logic [3:0] p, input logic [LEN_W-1:0] l);
    bus.pid[4*ep +: 4]         = p;
    bus.len[LEN_W*ep +: LEN_W] = l;
  endtask

  // PHY model: accepts bytes (with one spare cycle before each tx_ready)
  task automatic collect_packet(output bit timeout, output int idle_n, output logic [NUM_EP-1:0] g);
    int n;
    timeout = 1'b0;
    g = '0;
    got_q.delete();
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    idle_n = n;
    if (bus.tx_valid !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    g = bus.gnt;
    n = 0;
    while (bus.tx_valid === 1'b1 && n < 300) begin
      @(negedge clk);
      got_q.push_back(bus.tx_data);
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      n++;
    end
    if (bus.tx_valid === 1'b1) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.usb_reset = 1'b0;
    bus.req = '0;
    bus.pid = '0;
    bus.len = '0;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== '0) $display("FAIL rst_gnt got %b want 0", bus.gnt); else passes++;
    checks++; if (bus.done !== '0) $display("FAIL rst_done got %b want 0", bus.done); else passes++;
    checks++; if (bus.underrun !== 1'b0) $display("FAIL rst_underrun got %b want 0", bus.underrun); else passes++;
    checks++; if (bus.fifo_rdreq !== '0) $display("FAIL rst_rdreq got %b want 0", bus.fifo_rdreq); else passes++;
    checks++; if (bus.tx_data !== 8'h00) $display("FAIL rst_txdata got %02h want 00", bus.tx_data); else passes++;
    checks++; if (bus.tx_valid !== 1'b0) $display("FAIL rst_txvalid got %b want 0", bus.tx_valid); else passes++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit to;
    int idle;
    int d0 [NUM_EP];
    logic [NUM_EP-1:0] g;
    logic [3:0] pids [NUM_EP];
    logic [7:0] a, e;
    pids = '{4'hA, 4'h2, 4'h6, 4'hE};
    for (int i = 0; i < NUM_EP; i++) begin
      set_ep(i, pids[i], 7'd0);
      d0[i] = done_cnt[i];
    end
    bus.req = '1;
    pay_q.delete();
    for (int k = 0; k < 5; k++) begin
      push_pkt(pids[k % NUM_EP]);
      collect_packet(to, idle, g);
      checks++; if (to) $display("FAIL rr_timeout%0d got timeout want packet", k); else passes++;
      checks++; if (g !== NUM_EP'(1 << (k % NUM_EP))) $display("FAIL rr_gnt%0d got %b want %b", k, g, NUM_EP'(1 << (k % NUM_EP))); else passes++;
      if (k > 0) begin
        checks++; if (idle < GAP) $display("FAIL rr_gap%0d got %0d want >=%0d", k, idle, GAP); else passes++;
      end
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e || got_q.size() != 0) $display("FAIL rr_byte%0d got %02h (+%0d extra) want %02h", k, a, got_q.size(), e); else passes++;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[0] - d0[0] != 2) $display("FAIL rr_done0 got %0d want 2", done_cnt[0] - d0[0]); else passes++;
    checks++; if (done_cnt[3] - d0[3] != 1) $display("FAIL rr_done3 got %0d want 1", done_cnt[3] - d0[3]); else passes++;
  endtask

  task automatic test_pid_only();
    bit to;
    int idle, dn, rd;
    logic [NUM_EP-1:0] g;
    logic [7:0] a, e;
    set_ep(0, 4'b1010, 7'd5);
    dn = done_cnt[0];
    rd = rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    exp_q.push_back(8'h5A);
    bus.req = 4'b0001;
    collect_packet(to, idle, g);
    checks++; if (to) $display("FAIL ack_timeout got timeout want packet"); else passes++;
    checks++; if (g !== 4'b0001) $display("FAIL ack_gnt got %b want 0001", g); else passes++;
    checks++; if (bus.gnt !== '0 || bus.tx_valid !== 1'b0) $display("FAIL ack_end got gnt=%b valid=%b want 0 0", bus.gnt, bus.tx_valid); else passes++;
    bus.req = '0;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL ack_count got %0d want %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) $display("FAIL ack_byte%0d got %02h want %02h", i, a, e); else passes++;
    end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[0] - dn != 1) $display("FAIL ack_done got %0d want 1", done_cnt[0] - dn); else passes++;
    checks++; if (rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - rd != 0) $display("FAIL ack_rdreq got %0d want 0", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3] - rd); else passes++;
  endtask

  // Data packet on one endpoint; expected bytes already queued by caller
  task automatic test_data_packet(input string tag, input int ep, input int want_rd, input int want_und);
    bit to;
    int idle, dn, rd, un;
    logic [NUM_EP-1:0] g;
    logic [7:0] a, e;
    dn = done_cnt[ep];
    rd = rd_cnt[ep];
    un = und_cnt;
    bus.req = NUM_EP'(1 << ep);
    collect_packet(to, idle, g);
    bus.req = '0;
    checks++; if (to) $display("FAIL %s_timeout got timeout want packet", tag); else passes++;
    checks++; if (g !== NUM_EP'(1 << ep)) $display("FAIL %s_gnt got %b want %b", tag, g, NUM_EP'(1 << ep)); else passes++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL %s_count got %0d want %0d", tag, got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) $display("FAIL %s_byte%0d got %02h want %02h", tag, i, a, e); else passes++;
    end
    repeat (2) @(negedge clk);
    checks++; if (rd_cnt[ep] - rd != want_rd) $display("FAIL %s_rdreq got %0d want %0d", tag, rd_cnt[ep] - rd, want_rd); else passes++;
    checks++; if (done_cnt[ep] - dn != 1) $display("FAIL %s_done got %0d want 1", tag, done_cnt[ep] - dn); else passes++;
    checks++; if (und_cnt - un != want_und) $display("FAIL %s_underrun got %0d want %0d", tag, und_cnt - un, want_und); else passes++;
  endtask

  task automatic test_data0();
    set_ep(1, 4'b0011, 7'd1);
    fifo_push(1, 8'h00);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h00);
    exp_q.push_back(8'h40); exp_q.push_back(8'hBF);
    test_data_packet("data0", 1, 1, 0);
  endtask

  task automatic test_data1_len0();
    set_ep(2, 4'b1011, 7'd0);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    test_data_packet("len0", 2, 0, 0);
  endtask

  task automatic test_payload();
    set_ep(3, 4'b1011, 7'd5);
    pay_q.delete();
    for (int i = 0; i < 5; i++) begin
      pay_q.push_back(8'($urandom_range(0, 255)));
      fifo_push(3, pay_q[i]);
    end
    push_pkt(4'b1011);
    test_data_packet("payload", 3, 5, 0);
  endtask

  task automatic test_underrun();
    int ud;
    ud = und_done_cnt;
    set_ep(0, 4'b0011, 7'd3);
    fifo_push(0, 8'h5C);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h5C);
    test_data_packet("underrun", 0, 1, 1);
    checks++; if (und_done_cnt - ud != 1) $display("FAIL underrun_with_done got %0d want 1", und_done_cnt - ud); else passes++;
  endtask

  task automatic test_usb_reset();
    bit to;
    int idle, n, d1, d2;
    logic [NUM_EP-1:0] g;
    logic [7:0] a, e;
    d1 = done_cnt[1];
    d2 = done_cnt[2];
    set_ep(1, 4'b0011, 7'd3);
    fifo_push(1, 8'h11); fifo_push(1, 8'h22); fifo_push(1, 8'h33);
    bus.req = 4'b0010;
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.tx_valid !== 1'b1) $display("FAIL usbrst_start got valid=%b want 1", bus.tx_valid); else passes++;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    checks++; if (bus.tx_data !== 8'h11) $display("FAIL usbrst_first got %02h want 11", bus.tx_data); else passes++;
    bus.usb_reset = 1'b1;
    bus.req = '0;
    @(negedge clk);
    bus.usb_reset = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) $display("FAIL usbrst_valid got %b want 0", bus.tx_valid); else passes++;
    checks++; if (bus.gnt !== '0) $display("FAIL usbrst_gnt got %b want 0", bus.gnt); else passes++;
    fwr[1] = frd[1];
    set_ep(2, 4'b1010, 7'd0);
    pay_q.delete();
    push_pkt(4'b1010);
    bus.req = 4'b0100;
    collect_packet(to, idle, g);
    bus.req = '0;
    checks++; if (to || idle > 2) $display("FAIL usbrst_nogap got idle=%0d to=%0d want idle<=2", idle, to); else passes++;
    checks++; if (g !== 4'b0100) $display("FAIL usbrst_gnt2 got %b want 0100", g); else passes++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) $display("FAIL usbrst_byte%0d got %02h want %02h", i, a, e); else passes++;
    end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[1] - d1 != 0) $display("FAIL usbrst_nodone got %0d want 0", done_cnt[1] - d1); else passes++;
    checks++; if (done_cnt[2] - d2 != 1) $display("FAIL usbrst_done2 got %0d want 1", done_cnt[2] - d2); else passes++;
  endtask

  task automatic test_async_reset();
    bit to;
    int idle, n;
    logic [NUM_EP-1:0] g;
    set_ep(0, 4'b1010, 7'd0);
    set_ep(1, 4'b1010, 7'd0);
    bus.req = 4'b0001;
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || bus.gnt !== '0) $display("FAIL arst_immediate got valid=%b gnt=%b want 0 0", bus.tx_valid, bus.gnt); else passes++;
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0011;
    collect_packet(to, idle, g);
    bus.req = '0;
    checks++; if (to || g !== 4'b0001) $display("FAIL arst_rrptr got %b want 0001", g); else passes++;
    got_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_pid_only();
    test_data0();
    test_data1_len0();
    test_payload();
    test_underrun();
    test_usb_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Shares the transceiver TX channel (tx_data/tx_valid/tx_ready, SIE side) between NUM_EP endpoint requesters using round-robin arbitration.
- Sequences one packet per grant:
  - emits the PID byte;
  - for data PIDs, streams len bytes from the granted endpoint's show-ahead FIFO, then appends CRC16.
- Sits between the endpoint FIFOs and the PHY.

Parameters:
- NUM_EP, 4, number of requesting endpoints (2..8).
- LEN_W, 7, width of the per-endpoint packet length (max payload 2^LEN_W-1 bytes).
- GAP, 16, idle clocks enforced after tx_valid falls before the next arbitration (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- usb_reset  in  1  USB bus reset from PHY; synchronous abort to IDLE.
- req  in  NUM_EP  per-endpoint packet request; held until matching done.
- pid  in  4*NUM_EP  PID nibble per endpoint; ep i uses bits [4i+3:4i].
- len  in  LEN_W*NUM_EP  payload byte count per endpoint.
- gnt  out  NUM_EP  one-hot grant, high from grant cycle through done.
- done  out  NUM_EP  one-cycle pulse when the granted packet finishes or aborts.
- underrun  out  1  one-cycle pulse, together with done, on FIFO starvation.
- fifo_q  in  8*NUM_EP  show-ahead FIFO head data per endpoint.
- fifo_empty  in  NUM_EP  FIFO empty per endpoint.
- fifo_rdreq  out  NUM_EP  FIFO read acknowledge (pops head), granted endpoint only.
- tx_data  out  8  byte to PHY.
- tx_valid  out  1  rise starts SYNC; high while sending; fall triggers EOP.
- tx_ready  in  1  one-cycle pulse: current tx_data byte consumed.

Behaviour:
- Reset values: gnt=0, done=0, underrun=0, fifo_rdreq=0, tx_data=8'h00, tx_valid=0. Gap counter=0, RR pointer=NUM_EP-1 so ep0 has first priority. State=IDLE.
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP_WAIT.
- IDLE, with any req and gap counter 0:
  - select the first requesting ep after the RR pointer, searching cyclically;
  - register gnt, pid, len and update the RR pointer;
  - next cycle: state=PID, tx_valid=1, tx_data={~pid,pid}.
- PID type rule:
  - pid[1:0]==2'b11 is a data packet: payload plus CRC;
  - any other pid is PID-only, and len is ignored.
- PID state, on tx_ready:
  - PID-only: drop tx_valid next cycle, pulse done, go to GAP_WAIT;
  - data with len=0: go to CRC_LO;
  - data with len>0: go to DATA.
- Entering DATA and on each accepted data byte:
  - if a byte remains and fifo_empty is 0: tx_data<=fifo_q, fifo_rdreq pulses 1 cycle in the same cycle the byte is loaded, byte counter decrements;
  - CRC updated with the byte loaded.
- Byte timing: a new byte must be on tx_data the cycle after tx_ready, so the PHY never sees a stale byte.
- Underrun: granted FIFO empty when a payload byte is needed →
  - tx_valid drops next cycle;
  - done and underrun pulse;
  - go to GAP_WAIT;
  - no CRC is sent.
- After the last payload byte is accepted: CRC_LO.
- CRC: CRC-16/USB:
  - init 16'hFFFF, reflected poly 16'hA001, LSB first, one byte per cycle;
  - transmit ~crc, low byte (CRC_LO) then high byte (CRC_HI).
- On tx_ready in CRC_HI: drop tx_valid next cycle, pulse done, go to GAP_WAIT.
- gnt clears in the same cycle done pulses.
- GAP_WAIT: load gap counter=GAP, count to 0, return to IDLE. req sampled again only in IDLE.
- req is not re-checked during a packet; a drop of req mid-packet is ignored (packet completes).
- tx_ready outside PID/DATA/CRC states is ignored.
- usb_reset=1 in any state, next cycle:
  - IDLE, all outputs at reset values, gap counter 0;
  - no done pulse; RR pointer retained.
- reset asserted mid-packet: immediate return of all outputs to reset values.

Test Plan:
1. req=4'b0001, pid0=4'b1010 (ACK) → tx_data=8'h5A with tx_valid=1. After one tx_ready, tx_valid=0, done[0] pulse, no fifo_rdreq.
2. req[1], pid1=4'b0011 (DATA0), len1=1, FIFO holds 8'h00 → bytes 8'hC3, 8'h00, 8'h40, 8'hBF in that order. fifo_rdreq[1] pulses once, then done[1].
3. DATA1 (pid 4'b1011) with len=0 → bytes 8'h4B, 8'h00, 8'h00, then EOP.
4. req=4'b1111 held, PID-only packets → grants ep0,ep1,ep2,ep3,ep0. Each grant is separated by ≥GAP=16 idle cycles after tx_valid falls.
5. DATA0 len=3, FIFO holds 1 byte → 8'hC3 and byte sent, then tx_valid drops. underrun and done pulse together; no CRC bytes are sent.
6. usb_reset asserted during DATA → next cycle tx_valid=0, gnt=0, no done. Next req is served after IDLE, with no gap wait.
